// File: rtl/prim_subreg_mc_if.sv
// prim_subreg_mc_if: register-field bus between decode/control logic and a prim_subreg_mc slice
interface prim_subreg_mc_if #(
   parameter int DW  = 32,
   parameter int NHW = 2,
   parameter int CW  = 8
) ();
   logic                    we;
   logic [DW-1:0]           wd;
   logic                    re;
   logic [NHW-1:0]          de;
   logic [NHW-1:0][DW-1:0]  d;
   logic                    lock_set;
   logic                    cnt_clr;
   logic [DW-1:0]           q;
   logic                    qe;
   logic                    hw_upd;
   logic                    locked;
   logic [CW-1:0]           coll_cnt;
   modport master (output we, wd, re, de, d, lock_set, cnt_clr,
                   input  q, qe, hw_upd, locked, coll_cnt);
   modport slave  (input  we, wd, re, de, d, lock_set, cnt_clr,
                   output q, qe, hw_upd, locked, coll_cnt);
endinterface

// File: rtl/prim_subreg_mc.sv
// prim_subreg_mc: lockable multi-channel register field with SW/HW arbitration and collision counter
module prim_subreg_mc #(
   parameter int             DW       = 32,
   parameter int             NHW      = 2,
   parameter string          SWACCESS = "RW",
   parameter logic [DW-1:0]  RESVAL   = '0,
   parameter bit             LOCKABLE = 1'b1,
   parameter int             CW       = 8
) (
   input logic               clk_i,
   input logic               rst_i,
   prim_subreg_mc_if.slave   bus
);
   localparam bit IS_RC   = SWACCESS == "RC";
   localparam bit IS_RO   = SWACCESS == "RO";
   localparam bit IS_WR   = SWACCESS == "RW" || SWACCESS == "WO";
   localparam bit IS_SET  = SWACCESS == "W1S" || SWACCESS == "W1SS";
   localparam bit IS_CLR  = SWACCESS == "W1C" || SWACCESS == "W1CS";
   localparam bit IS_W0C  = SWACCESS == "W0C";
   localparam bit IS_W1SS = SWACCESS == "W1SS";
   localparam bit IS_W1CS = SWACCESS == "W1CS";

   logic [DW-1:0] q, hw_d, b, n, f, q_next;
   logic [CW-1:0] cnt;
   logic          hw_de, multi, sw, coll, locked, qe, hw_upd;

   // lowest-index channel wins; scan from the top so it overwrites last
   always_comb begin
      hw_d = '0;
      for (int i = NHW - 1; i >= 0; i--) hw_d = bus.de[i] ? bus.d[i] : hw_d;
   end

   assign hw_de  = |bus.de;
   assign multi  = (bus.de & (bus.de - NHW'(1))) != '0;
   assign sw     = IS_RC ? bus.re : (IS_RO ? 1'b0 : bus.we & ~locked);
   assign coll   = (sw & hw_de) | multi | (bus.we & locked & ~IS_RC);
   assign b      = hw_de ? hw_d : q;
   assign n      = IS_WR  ? (sw ? bus.wd : b) :
                   IS_SET ? (b | (sw ? bus.wd : '0)) :
                   IS_CLR ? (b & (sw ? ~bus.wd : '1)) :
                   IS_W0C ? (b & (sw ? bus.wd : '1)) :
                   IS_RC  ? (sw ? '0 : b) : b;
   assign f      = IS_W1SS ? q : (IS_W1CS ? ~q : '0);
   assign q_next = (f & q) | (~f & n);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q      <= RESVAL;
         qe     <= 1'b0;
         hw_upd <= 1'b0;
         locked <= 1'b0;
         cnt    <= '0;
      end else begin
         q      <= (sw | hw_de) ? q_next : q;
         qe     <= sw;
         hw_upd <= hw_de;
         locked <= locked | (LOCKABLE & bus.lock_set);
         cnt    <= bus.cnt_clr ? '0 : ((coll && cnt != '1) ? cnt + CW'(1) : cnt);
      end
   end

   assign bus.q        = q;
   assign bus.qe       = qe;
   assign bus.hw_upd   = hw_upd;
   assign bus.locked   = locked;
   assign bus.coll_cnt = cnt;
endmodule

// File: tb/tb_prim_subreg_mc.sv
// tb_prim_subreg_mc: directed checks of RW/W1C/W1SS/RC slices, lock, counter and async reset
module tb_prim_subreg_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   prim_subreg_mc_if #(.DW(8), .NHW(2), .CW(2)) r ();
   prim_subreg_mc_if #(.DW(8), .NHW(2), .CW(8)) c ();
   prim_subreg_mc_if #(.DW(8), .NHW(2), .CW(8)) s ();
   prim_subreg_mc_if #(.DW(8), .NHW(2), .CW(8)) k ();

   prim_subreg_mc #(.DW(8), .NHW(2), .SWACCESS("RW"), .RESVAL(8'h00), .LOCKABLE(1'b1), .CW(2))
      u_rw (.clk_i(clk), .rst_i(rst), .bus(r));
   prim_subreg_mc #(.DW(8), .NHW(2), .SWACCESS("W1C"), .RESVAL(8'h00), .LOCKABLE(1'b1), .CW(8))
      u_w1c (.clk_i(clk), .rst_i(rst), .bus(c));
   prim_subreg_mc #(.DW(8), .NHW(2), .SWACCESS("W1SS"), .RESVAL(8'h00), .LOCKABLE(1'b1), .CW(8))
      u_w1ss (.clk_i(clk), .rst_i(rst), .bus(s));
   prim_subreg_mc #(.DW(8), .NHW(2), .SWACCESS("RC"), .RESVAL(8'h5A), .LOCKABLE(1'b1), .CW(8))
      u_rc (.clk_i(clk), .rst_i(rst), .bus(k));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      r.we = 0; r.wd = 0; r.re = 0; r.de = 0; r.d = '0; r.lock_set = 0; r.cnt_clr = 0;
      c.we = 0; c.wd = 0; c.re = 0; c.de = 0; c.d = '0; c.lock_set = 0; c.cnt_clr = 0;
      s.we = 0; s.wd = 0; s.re = 0; s.de = 0; s.d = '0; s.lock_set = 0; s.cnt_clr = 0;
      k.we = 0; k.wd = 0; k.re = 0; k.de = 0; k.d = '0; k.lock_set = 0; k.cnt_clr = 0;
   endtask

   initial begin
      idle();
      #12;
      chk("rst_q", r.q, 8'h00);
      chk("rst_qe", r.qe, 0);
      chk("rst_hw_upd", r.hw_upd, 0);
      chk("rst_locked", r.locked, 0);
      chk("rst_cnt", r.coll_cnt, 0);
      chk("rst_rc_q", k.q, 8'h5A);
      rst = 0;
      // two HW channels at once: channel 0 wins, one collision
      r.de = 2'b11; r.d[0] = 8'hA5; r.d[1] = 8'h5A;
      tick();
      chk("hw_prio_q", r.q, 8'hA5);
      chk("hw_prio_upd", r.hw_upd, 1);
      chk("hw_prio_qe", r.qe, 0);
      chk("hw_prio_cnt", r.coll_cnt, 1);
      r.de = 2'b10; r.d[1] = 8'h34; r.we = 1; r.wd = 8'h12;
      tick();
      chk("sw_hw_q", r.q, 8'h12);
      chk("sw_hw_qe", r.qe, 1);
      chk("sw_hw_upd", r.hw_upd, 1);
      chk("sw_hw_cnt", r.coll_cnt, 2);
      idle();
      tick();
      chk("idle_q", r.q, 8'h12);
      chk("idle_qe", r.qe, 0);
      chk("idle_upd", r.hw_upd, 0);
      // W1C: SW clears beat simultaneous HW set
      c.de = 2'b01; c.d[0] = 8'hF0;
      tick();
      c.d[0] = 8'hFF; c.we = 1; c.wd = 8'h30;
      tick();
      chk("w1c_q", c.q, 8'hCF);
      chk("w1c_qe", c.qe, 1);
      chk("w1c_cnt", c.coll_cnt, 1);
      idle();
      // W1SS: bits already set resist the HW clear
      s.de = 2'b01; s.d[0] = 8'h0F;
      tick();
      s.d[0] = 8'h00; s.we = 1; s.wd = 8'h30;
      tick();
      chk("w1ss_q", s.q, 8'h3F);
      idle();
      // RC: writes ignored, read clears even against a HW write
      k.we = 1; k.wd = 8'hFF;
      tick();
      chk("rc_we_q", k.q, 8'h5A);
      chk("rc_we_qe", k.qe, 0);
      chk("rc_we_cnt", k.coll_cnt, 0);
      k.we = 0; k.re = 1; k.de = 2'b01; k.d[0] = 8'h33;
      tick();
      chk("rc_rd_q", k.q, 8'h00);
      chk("rc_rd_qe", k.qe, 1);
      chk("rc_rd_cnt", k.coll_cnt, 1);
      idle();
      // lock: same-cycle write lands, later writes blocked, HW still writes
      r.lock_set = 1; r.we = 1; r.wd = 8'h77;
      tick();
      chk("lock_q", r.q, 8'h77);
      chk("lock_locked", r.locked, 1);
      chk("lock_cnt", r.coll_cnt, 2);
      r.lock_set = 0; r.wd = 8'h11;
      tick();
      chk("blk_q", r.q, 8'h77);
      chk("blk_qe", r.qe, 0);
      chk("blk_cnt", r.coll_cnt, 3);
      r.we = 0; r.de = 2'b01; r.d[0] = 8'h22;
      tick();
      chk("lock_hw_q", r.q, 8'h22);
      chk("lock_hw_upd", r.hw_upd, 1);
      chk("lock_hw_cnt", r.coll_cnt, 3);
      idle();
      // asynchronous reset mid-cycle
      r.we = 1; r.wd = 8'h55;
      #2 rst = 1;
      #1;
      chk("arst_q", r.q, 8'h00);
      chk("arst_locked", r.locked, 0);
      chk("arst_cnt", r.coll_cnt, 0);
      chk("arst_rc_q", k.q, 8'h5A);
      rst = 0; r.wd = 8'h66;
      tick();
      chk("post_rst_q", r.q, 8'h66);
      chk("post_rst_qe", r.qe, 1);
      idle();
      // counter saturation and clear priority
      r.de = 2'b11; r.d[0] = 8'h01; r.d[1] = 8'h02;
      tick();
      tick();
      chk("cnt_two", r.coll_cnt, 2);
      tick();
      tick();
      chk("cnt_sat", r.coll_cnt, 3);
      r.cnt_clr = 1;
      tick();
      chk("cnt_clr", r.coll_cnt, 0);
      r.cnt_clr = 0;
      tick();
      chk("cnt_after_clr", r.coll_cnt, 1);
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/prim_subreg_mc.md
# prim_subreg_mc

Multi-channel, lockable register field slice. It stores one DW-bit field and arbitrates software writes against NHW hardware write channels per the configured software access mode. It also provides an optional sticky software lock, registered update strobes and a saturating collision counter. It sits between the register-interface decode and the IOPMP control/status logic, one instance per register field.

## Interface
Parameters:
- DW, 32, field width in bits (1..64).
- NHW, 2, number of hardware write channels (1..8); lower index has higher priority.
- SWACCESS, "RW", one of RW, WO, RO, W1C, W1S, W0C, RC, W1SS, W1CS.
- RESVAL, '0, DW-bit reset value of the field.
- LOCKABLE, 1, 1 enables the sticky software lock; 0 ties `locked` low.
- CW, 8, collision counter width (1..16).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- we  in  1  software write strobe (ignored for RO and RC).
- wd  in  DW  software write data.
- re  in  1  software read strobe; used only by RC.
- de  in  NHW  hardware write enables.
- d  in  NHW x DW  hardware write data, one word per channel.
- lock_set  in  1  single-cycle pulse; sets the lock when LOCKABLE=1.
- cnt_clr  in  1  clears the collision counter.
- q  out  DW  current field value.
- qe  out  1  one-cycle pulse; the field was updated by an accepted software write.
- hw_upd  out  1  one-cycle pulse; the field was updated by a hardware write.
- locked  out  1  sticky lock state.
- coll_cnt  out  CW  saturating collision count.

## Operation
- Reset values: q=RESVAL, qe=0, hw_upd=0, locked=0, coll_cnt=0.
- HW merge: hw_de = |de. hw_d = d[i] for the lowest i with de[i]=1. Higher-index data in the same cycle is discarded.
- Effective SW strobe sw = we & ~locked, except in RC mode, where sw = re. Reads in RC mode are never blocked by the lock.
- Base value b = hw_de ? hw_d : q.
- Candidate value n per mode:
  - RW/WO: sw ? wd : b.
  - RO: b.
  - W1S: b | (sw ? wd : 0).
  - W1C: b & (sw ? ~wd : all-ones).
  - W0C: b & (sw ? wd : all-ones).
  - RC: sw ? 0 : b.
  - W1SS: as W1S, with per-bit freeze mask F = q.
  - W1CS: as W1C, with per-bit freeze mask F = ~q.
- Final next value: q_next = (F & q) | (~F & n). F=0 for all modes except W1SS and W1CS.
- Update occurs when sw | hw_de. If the update leaves q unchanged, q is still rewritten.
- Lock:
  - locked sets on lock_set when LOCKABLE=1, and stays set until reset.
  - A `we` in the same cycle as lock_set is still accepted; the lock gates writes from the next cycle.
  - Hardware writes are never blocked by the lock.
- Collision event in a cycle:
  - sw & hw_de, or
  - two or more de bits set, or
  - we & locked (a blocked write, not counted in RC mode).
  - One increment per cycle regardless of how many conditions hold.
- Counter:
  - Saturates at 2^CW-1.
  - cnt_clr has priority over an increment in the same cycle; the counter reads 0 after that edge.

## Timing
- q, qe, hw_upd, locked and coll_cnt are all registered; there are no combinational input-to-output paths.
- Write latency is 1 cycle: inputs sampled at edge k appear on q after edge k.
- qe=1 during the cycle following an accepted sw, aligned with the new q. Back-to-back writes give qe held high.
- In RC mode, qe pulses for an accepted read-clear.
- hw_upd=1 in the cycle after any hw_de. When SW and HW update together, qe and hw_upd are both 1.
- Asserting rst_i mid-operation immediately forces all outputs to reset values, regardless of clock. The first update after deassertion occurs at the first rising edge with rst_i low.

## Test plan
- RW, NHW=2, RESVAL=0:
  - de=2'b11, d[0]=0xA5, d[1]=0x5A -> q=0xA5 next cycle, hw_upd=1, coll_cnt=1.
  - Then we=1, wd=0x12 with de[1]=1 -> q=0x12, qe=1, hw_upd=1, coll_cnt=2.
- W1C:
  - q=0xF0; de[0]=1, d[0]=0xFF with we=1, wd=0x30 -> q=0xCF. The SW-cleared bits win and the HW-set bits persist.
- W1SS:
  - q=0x0F; de[0]=1, d[0]=0x00; we=1, wd=0x30 -> q=0x3F. Set bits are frozen against the HW clear.
- Lock, RW:
  - lock_set and we (wd=0x77) in the same cycle -> q=0x77, locked=1.
  - Next cycle we (wd=0x11) -> q stays 0x77, qe=0, coll_cnt increments.
  - de[0] with 0x22 -> q=0x22.
- Counter:
  - CW=2; four collision cycles -> coll_cnt=3 (saturated).
  - cnt_clr together with a collision -> coll_cnt=0.
  - rst_i asserted mid-write -> q=RESVAL and locked=0 immediately.
